// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the decode-to-execute control pipeline register.
// The control word is one packed struct so the flop stage stays a single vector.
package pipe_ctrl_pkg;

    localparam int ALU_CTRL_W = 4;

    // Field order mirrors the port order; flag_w lands in the MSB.
    typedef struct packed {
        logic                  flag_w;
        logic                  reg_write;
        logic                  memto_reg;
        logic                  mem_write;
        logic                  branch;
        logic                  alu_src;
        logic                  no_write;
        logic                  cond;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
    } ctrl_de_t;

    localparam ctrl_de_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline flop: async active-low reset, synchronous clear, load enable.
// Clear wins over enable so a flush still lands while the stage is held.
module pipe_reg_en_clr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pipe_cont_unit_d_to_e.sv
// Decode-to-execute register for control-unit outputs; flush inserts a bubble.
// Define PIPE_CU_STALL_EN to add the StallE hold input.
module pipe_cont_unit_d_to_e
    import pipe_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = pipe_ctrl_pkg::ALU_CTRL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  FlagWD,
    input  logic                  RegWriteD,
    input  logic                  MemtoRegD,
    input  logic                  MemWriteD,
    input  logic                  BranchD,
    input  logic                  ALUSrcD,
    input  logic                  NoWriteD,
    input  logic                  CondD,
    input  logic [ALU_CTRL_W-1:0] ALUControlD,
    output logic                  FlagWE,
    output logic                  RegWriteE,
    output logic                  MemtoRegE,
    output logic                  MemWriteE,
    output logic                  BranchE,
    output logic                  ALUSrcE,
    output logic                  NoWriteE,
    output logic                  CondE,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
`ifdef PIPE_CU_STALL_EN
    input  logic                  FlushE,
    input  logic                  StallE
`else
    input  logic                  FlushE
`endif
);

    ctrl_de_t ctrl_d, ctrl_e;
    logic     load_en;

    // No decoding here: NoWrite/RegWrite combinations pass through untouched.
    always_comb begin
        ctrl_d           = CTRL_BUBBLE;
        ctrl_d.flag_w    = FlagWD;
        ctrl_d.reg_write = RegWriteD;
        ctrl_d.memto_reg = MemtoRegD;
        ctrl_d.mem_write = MemWriteD;
        ctrl_d.branch    = BranchD;
        ctrl_d.alu_src   = ALUSrcD;
        ctrl_d.no_write  = NoWriteD;
        ctrl_d.cond      = CondD;
        ctrl_d.alu_ctrl  = ALUControlD;
    end

`ifdef PIPE_CU_STALL_EN
    assign load_en = ~StallE;
`else
    assign load_en = 1'b1;
`endif

    pipe_reg_en_clr #(
        .W ($bits(ctrl_de_t))
    ) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst),
        .clr   (FlushE),
        .en    (load_en),
        .d     (ctrl_d),
        .q     (ctrl_e)
    );

    assign FlagWE      = ctrl_e.flag_w;
    assign RegWriteE   = ctrl_e.reg_write;
    assign MemtoRegE   = ctrl_e.memto_reg;
    assign MemWriteE   = ctrl_e.mem_write;
    assign BranchE     = ctrl_e.branch;
    assign ALUSrcE     = ctrl_e.alu_src;
    assign NoWriteE    = ctrl_e.no_write;
    assign CondE       = ctrl_e.cond;
    assign ALUControlE = ctrl_e.alu_ctrl;

endmodule

// File: tb/tb_pipe_cont_unit_d_to_e.sv
// Directed bench for pipe_cont_unit_d_to_e; stall vectors run when PIPE_CU_STALL_EN is defined.
module tb_pipe_cont_unit_d_to_e;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] bits_d = '0;
    logic [3:0] alu_d = '0;
    logic [7:0] bits_e;
    logic [3:0] alu_e;
`ifdef PIPE_CU_STALL_EN
    logic       stall = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_cont_unit_d_to_e dut (
        .clk         (clk),
        .rst         (rst),
        .FlagWD      (bits_d[7]),
        .RegWriteD   (bits_d[6]),
        .MemtoRegD   (bits_d[5]),
        .MemWriteD   (bits_d[4]),
        .BranchD     (bits_d[3]),
        .ALUSrcD     (bits_d[2]),
        .NoWriteD    (bits_d[1]),
        .CondD       (bits_d[0]),
        .ALUControlD (alu_d),
        .FlagWE      (bits_e[7]),
        .RegWriteE   (bits_e[6]),
        .MemtoRegE   (bits_e[5]),
        .MemWriteE   (bits_e[4]),
        .BranchE     (bits_e[3]),
        .ALUSrcE     (bits_e[2]),
        .NoWriteE    (bits_e[1]),
        .CondE       (bits_e[0]),
        .ALUControlE (alu_e),
`ifdef PIPE_CU_STALL_EN
        .FlushE      (flush),
        .StallE      (stall)
`else
        .FlushE      (flush)
`endif
    );

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b_%b, expected %b_%b", tag, got[11:4], got[3:0], exp[11:4], exp[3:0]);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic [3:0] a);
        bits_d = b;
        alu_d  = a;
    endtask

    initial begin
        // Inputs present before any reset, mid-cycle async reset pulse.
        drive(8'b10101011, 4'b1110);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 chk("async_reset_immediate", {bits_e, alu_e}, 12'h000);
        @(posedge clk);
        #1 chk("reset_held_through_edge", {bits_e, alu_e}, 12'h000);
        @(negedge clk);
        rst = 1'b1;
        drive(8'b11111111, 4'b1111);
        #1 chk("no_capture_before_edge", {bits_e, alu_e}, 12'h000);

        @(negedge clk);
        chk("capture_all_ones", {bits_e, alu_e}, {8'b11111111, 4'b1111});
        drive(8'b01001000, 4'b0100);
        #2 chk("no_comb_path", {bits_e, alu_e}, {8'b11111111, 4'b1111});

        @(negedge clk);
        chk("capture_regwrite_branch", {bits_e, alu_e}, {8'b01001000, 4'b0100});

        drive(8'b01000010, 4'b1001);
        @(negedge clk);
        chk("nowrite_regwrite_passthru", {bits_e, alu_e}, {8'b01000010, 4'b1001});

        drive(8'b11111111, 4'b1111);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_bubble", {bits_e, alu_e}, 12'h000);
        flush = 1'b0;
        @(negedge clk);
        chk("reload_after_flush", {bits_e, alu_e}, {8'b11111111, 4'b1111});

        drive(8'b10101011, 4'b1110);
        @(negedge clk);
        chk("capture_pattern_aa", {bits_e, alu_e}, {8'b10101011, 4'b1110});

`ifdef PIPE_CU_STALL_EN
        stall = 1'b1;
        drive(8'b00000000, 4'b0000);
        @(negedge clk);
        chk("stall_hold_1", {bits_e, alu_e}, {8'b10101011, 4'b1110});
        @(negedge clk);
        chk("stall_hold_2", {bits_e, alu_e}, {8'b10101011, 4'b1110});
        drive(8'b00110101, 4'b0011);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_beats_stall", {bits_e, alu_e}, 12'h000);
        flush = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk("resume_after_stall", {bits_e, alu_e}, {8'b00110101, 4'b0011});
        stall = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async_reset_during_stall", {bits_e, alu_e}, 12'h000);
        @(negedge clk);
        stall = 1'b0;
        rst   = 1'b1;
`else
        drive(8'b00110101, 4'b0011);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async_reset_loaded", {bits_e, alu_e}, 12'h000);
        @(negedge clk);
        rst = 1'b1;
`endif

        drive(8'b00010100, 4'b0110);
        @(negedge clk);
        chk("capture_after_rereset", {bits_e, alu_e}, {8'b00010100, 4'b0110});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_cont_unit_d_to_e.md
Name: pipe_cont_unit_d_to_e

Overview:
- Decode-to-Execute pipeline register for the control-unit outputs of the 5-stage ARM-like pipeline.
- Captures the decode-stage control bits and the ALU control code on the rising clock edge.
- Presents them to the execute stage one cycle later.
- Supports a bubble-inserting flush; a pipeline stall is available through the optional feature.

Parameters:
- ALU_CTRL_W, 4, width of ALUControlD/ALUControlE.

Ports:
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- FlushE  input  1  synchronous bubble insert; tie 0 if unused.
- FlagWD  input  1  decode-stage flag-write enable.
- RegWriteD  input  1  register-file write enable.
- MemtoRegD  input  1  write-back mux select (memory vs ALU).
- MemWriteD  input  1  data-memory write enable.
- BranchD  input  1  branch instruction.
- ALUSrcD  input  1  ALU B-operand select (immediate vs register).
- NoWriteD  input  1  compare-type op; suppresses register write.
- CondD  input  1  conditional-execution marker.
- ALUControlD  input  ALU_CTRL_W  ALU operation code.
- FlagWE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, NoWriteE, CondE  output  1 each  registered copies of the matching D inputs.
- ALUControlE  output  ALU_CTRL_W  registered ALU operation code.
- StallE  input  1  hold current contents; present only with PIPE_CU_STALL_EN.

Port order: clk, rst, FlagWD … CondD, ALUControlD, FlagWE … CondE, ALUControlE, then FlushE (and StallE, if compiled in) last.

Behaviour:
- Reset
  - rst=0 asynchronously forces every output to 0, including ALUControlE=0.
  - The cleared state is a bubble: no register write, no memory write, no branch, no flag write.
  - Outputs stay 0 while rst=0, regardless of clk.
  - On rst deassertion, the first capture happens at the next rising clk edge.
- Normal operation
  - At each rising edge with rst=1, every E output takes its D input's value at that edge.
  - Latency is exactly 1 cycle; no combinational path from any D input to any E output.
- Flush
  - FlushE=1 at an edge loads all outputs with 0 (bubble) instead of the D inputs.
  - The clear is synchronous.
- Priority: reset > flush > stall > capture.
- All signals are treated as independent bits; there is no decoding or validation of combinations.
  - NoWriteD=1 with RegWriteD=1 is passed through unchanged; gating happens downstream.
- Outputs are X-free after the first reset.
- Reset asserted mid-cycle clears the outputs immediately, without waiting for clk.

Optional Feature:
- PIPE_CU_STALL_EN defined:
  - Adds input StallE.
  - StallE=1 at an edge (no flush) holds all outputs at their previous values.
  - FlushE=1 together with StallE=1 still flushes.
- Macro undefined:
  - No StallE port.
  - The register captures every cycle unless flushed or reset.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - ALU_CTRL_W default constant.
  - A packed struct ctrl_de_t with the eight 1-bit fields in port order plus the ALU control field.
  - Constant CTRL_BUBBLE (all zero).
- Natural sub-module: pipe_reg_en_clr, a generic width-parameterised flop with async active-low reset, sync clear and enable.
  - Instantiate it once over the packed struct.

Test Plan:
- Reset: before any reset, apply {FlagWD..CondD}=8'b10101011 and ALUControlD=4'b1110. Pulse rst=0 mid-cycle → all outputs 0 immediately, held through the edge while rst=0.
- Capture: rst=1, inputs 8'b11111111 and ALUControlD=4'b1111 → after the next rising edge all eight E bits are 1 and ALUControlE=4'b1111. Outputs do not change between edges.
- Next capture: inputs 8'b01001000 and ALUControlD=4'b0100 → next edge gives RegWriteE=1, BranchE=1, all other bits 0, ALUControlE=4'b0100.
- Flush: inputs 8'b11111111 with FlushE=1 → next edge all outputs 0. Drop FlushE → the following edge reloads the inputs.
- Stall (macro on): latch 8'b10101011/4'b1110, then StallE=1 with inputs changed to 0 → outputs hold 8'b10101011/4'b1110. StallE=1 and FlushE=1 together → outputs 0.
- Async reset during stall: StallE=1, rst=0 between edges → outputs 0 without a clock edge.
